// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - immediate format select encodings and supported widths
package imm_pkg;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;
  localparam logic [2:0] IMM_Z = 3'b101;

  localparam int XLEN_32 = 32;
  localparam int XLEN_64 = 64;

endpackage

// File: rtl/imm_format.sv
// rtl/imm_format.sv - combinational RISC-V immediate extraction and extension
module imm_format
  import imm_pkg::*;
#(
  parameter int XLEN = XLEN_32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic sgn;
  logic unused_opcode;

  assign sgn           = instr[31];
  // The opcode field carries no immediate bits in any format.
  assign unused_opcode = ^instr[6:0];

  // Select and sign/zero-extend the immediate; illegal selects yield zero.
  // U keeps instr[31] inside the replicated run so the concatenation stays
  // well-formed at XLEN=32 while still sign-extending at XLEN=64.
  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_sel)
      IMM_I:   imm = {{(XLEN-12){sgn}}, instr[31:20]};
      IMM_S:   imm = {{(XLEN-12){sgn}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{(XLEN-13){sgn}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{(XLEN-31){sgn}}, instr[30:12], 12'b0};
      IMM_J:   imm = {{(XLEN-21){sgn}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   imm = {{(XLEN-5){1'b0}}, instr[19:15]};
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - immediate generator with 2-entry in-order output FIFO
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN  = XLEN_32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [2:0]       imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  imm_out,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0]  fmt_imm;
  logic             fmt_illegal;

  logic [XLEN-1:0]  imm_q [2];
  logic [TAG_W-1:0] tag_q [2];
  logic [1:0]       ill_q;

  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic             accept;
  logic             consume;

  imm_format #(.XLEN(XLEN)) u_imm_format (
    .instr   (instr),
    .imm_sel (imm_sel),
    .imm     (fmt_imm),
    .illegal (fmt_illegal)
  );

  // Handshakes depend only on registered occupancy, never on out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = out_valid && out_ready;

  // Head entry is read straight from storage, so it holds while stalled.
  assign imm_out     = imm_q[rd_ptr_q];
  assign out_tag     = tag_q[rd_ptr_q];
  assign out_illegal = ill_q[rd_ptr_q];

  // Next pointers and occupancy; flush wins over any accept or consume.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (accept) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (consume) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      count_d = count_q + {1'b0, accept} - {1'b0, consume};
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head outputs read zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        imm_q[i] <= '0;
        tag_q[i] <= '0;
      end
      ill_q <= 2'b00;
    end else if (accept) begin
      imm_q[wr_ptr_q] <= fmt_imm;
      tag_q[wr_ptr_q] <= in_tag;
      ill_q[wr_ptr_q] <= fmt_illegal;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - self-checking bench for imm_gen_pipe
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [4:0]  tag;
    logic [31:0] e32;
    logic [63:0] e64;
    logic        ill;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] instr;
  logic [2:0]  imm_sel;
  logic [4:0]  in_tag;

  logic        ir32, ov32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        ir64, ov64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int   checks;
  int   failures;
  vec_t tbl [14];
  vec_t sb [$];
  vec_t cur;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir32),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov32),
    .out_ready(out_ready), .imm_out(imm32), .out_tag(tag32), .out_illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir64),
    .instr(instr), .imm_sel(imm_sel), .in_tag(in_tag), .out_valid(ov64),
    .out_ready(out_ready), .imm_out(imm64), .out_tag(tag64), .out_illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one entry starting just after a rising edge; returns just after
  // the edge that accepted it, leaving in_valid high.
  task automatic send(input vec_t v);
    bit ok;
    ok       = 1'b0;
    cur      = v;
    instr    = v.instr;
    imm_sel  = v.sel;
    in_tag   = v.tag;
    in_valid = 1'b1;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (ir32) ok = 1'b1;
      step();
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout tag=%0d not accepted within 50 cycles", v.tag);
    end
  endtask

  // Scoreboard: push on accept, pop and compare on consume.
  always @(negedge clk) begin
    vec_t e;
    if (rst || flush) begin
      sb.delete();
    end else begin
      if (ov32 && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out actual_tag=%0d required=no output", tag32);
        end else begin
          e = sb.pop_front();
          chk("imm32", 64'(imm32), 64'(e.e32));
          chk("imm64", imm64, e.e64);
          chk("tag", 64'(tag32), 64'(e.tag));
          chk("tag64", 64'(tag64), 64'(e.tag));
          chk("illegal", 64'(ill32), 64'(e.ill));
          chk("illegal64", 64'(ill64), 64'(e.ill));
          chk("ov64", 64'(ov64), 64'd1);
        end
      end
      if (in_valid && ir32) sb.push_back(cur);
    end
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    instr     = '0;
    imm_sel   = '0;
    in_tag    = '0;

    tbl[0]  = '{32'hFFF00093, 3'b000, 5'd1,  32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0};
    tbl[1]  = '{32'h12345037, 3'b011, 5'd2,  32'h12345000, 64'h0000000012345000, 1'b0};
    tbl[2]  = '{32'h80000000, 3'b010, 5'd3,  32'hFFFFF000, 64'hFFFFFFFFFFFFF000, 1'b0};
    tbl[3]  = '{32'h80000000, 3'b100, 5'd4,  32'hFFF00000, 64'hFFFFFFFFFFF00000, 1'b0};
    tbl[4]  = '{32'h000F8000, 3'b101, 5'd5,  32'h0000001F, 64'h000000000000001F, 1'b0};
    tbl[5]  = '{32'h80000037, 3'b011, 5'd6,  32'h80000000, 64'hFFFFFFFF80000000, 1'b0};
    tbl[6]  = '{32'hFFFFFFFF, 3'b110, 5'd7,  32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[7]  = '{32'hFFFFFFFF, 3'b111, 5'd8,  32'h00000000, 64'h0000000000000000, 1'b1};
    tbl[8]  = '{32'h00A00523, 3'b001, 5'd9,  32'h0000000A, 64'h000000000000000A, 1'b0};
    tbl[9]  = '{32'h80000080, 3'b001, 5'd10, 32'hFFFFF801, 64'hFFFFFFFFFFFFF801, 1'b0};
    tbl[10] = '{32'h7FF00013, 3'b000, 5'd11, 32'h000007FF, 64'h00000000000007FF, 1'b0};
    tbl[11] = '{32'h7E000F80, 3'b010, 5'd12, 32'h00000FFE, 64'h0000000000000FFE, 1'b0};
    tbl[12] = '{32'h7FFFF000, 3'b100, 5'd13, 32'h000FFFFE, 64'h00000000000FFFFE, 1'b0};
    tbl[13] = '{32'hFFFFFFFF, 3'b101, 5'd14, 32'h0000001F, 64'h000000000000001F, 1'b0};

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 64'(ov32), 64'd0);
    chk("rst_in_ready", 64'(ir32), 64'd1);
    chk("rst_imm32", 64'(imm32), 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    chk("rst_tag", 64'(tag32), 64'd0);
    chk("rst_illegal", 64'(ill32), 64'd0);

    // First accept on first edge after deassert, one-cycle latency
    step();
    rst = 1'b0;
    send(tbl[0]);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", 64'(ov32), 64'd1);
    step();
    @(negedge clk);
    chk("drained_valid", 64'(ov32), 64'd0);
    step();

    // Table vectors, streaming with out_ready high
    for (int i = 1; i < 14; i++) send(tbl[i]);
    in_valid = 1'b0;
    repeat (3) step();
    chk("table_drained", 64'(sb.size()), 64'd0);

    // Backpressure: fill to two, third held upstream, head stable
    out_ready = 1'b0;
    send(tbl[0]);
    send(tbl[1]);
    cur      = tbl[2];
    instr    = tbl[2].instr;
    imm_sel  = tbl[2].sel;
    in_tag   = tbl[2].tag;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 64'(ir32), 64'd0);
      chk("hold_tag", 64'(tag32), 64'd1);
      chk("hold_imm", 64'(imm32), 64'hFFFFFFFF);
    end
    step();
    out_ready = 1'b1;
    send(tbl[2]);
    in_valid = 1'b0;
    repeat (4) step();
    chk("bp_drained", 64'(sb.size()), 64'd0);

    // Flush at count 2 with a same-cycle incoming entry
    out_ready = 1'b0;
    send(tbl[3]);
    send(tbl[4]);
    cur      = tbl[5];
    instr    = tbl[5].instr;
    imm_sel  = tbl[5].sel;
    in_tag   = tbl[5].tag;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 64'(ov32), 64'd0);
    chk("flush_in_ready", 64'(ir32), 64'd1);
    step();
    out_ready = 1'b1;
    repeat (3) step();
    send(tbl[6]);
    in_valid = 1'b0;
    repeat (3) step();
    chk("flush_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset mid-cycle with two entries stored
    out_ready = 1'b0;
    send(tbl[7]);
    send(tbl[8]);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(ov32), 64'd0);
    chk("arst_in_ready", 64'(ir32), 64'd1);
    chk("arst_imm", 64'(imm32), 64'd0);
    chk("arst_tag", 64'(tag32), 64'd0);
    chk("arst_illegal", 64'(ill32), 64'd0);
    @(negedge clk);
    step();
    rst       = 1'b0;
    out_ready = 1'b1;
    send(tbl[9]);
    in_valid = 1'b0;
    repeat (3) step();
    chk("arst_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
